// File: rtl/seq_shift_unit_if.sv
// ----------------------------------------------------------------------------
// seq_shift_unit_if
//   Bundles the command, data and status signals of seq_shift_unit.
//   The clock and reset are not part of this interface.
//
//   Parameters
//     W   data width
//     AW  shift-amount width
//
//   Signals
//     ld        load data_in (honoured only while idle)
//     start     start a shift operation (honoured only while idle)
//     mode      3-bit shift mode
//     amt       number of single-bit steps
//     data_in   parallel load value
//     data_out  shift register contents
//     shift_out last bit shifted out of data_out
//     busy      operation in progress
//     done      one-cycle completion pulse
//
//   Modports
//     master  drives the commands and reads the status (the requester)
//     slave   receives the commands and drives the status (the shift unit)
// ----------------------------------------------------------------------------
interface seq_shift_unit_if #(
  parameter int W  = 8,
  parameter int AW = 4
);
  logic          ld;
  logic          start;
  logic [2:0]    mode;
  logic [AW-1:0] amt;
  logic [W-1:0]  data_in;
  logic [W-1:0]  data_out;
  logic          shift_out;
  logic          busy;
  logic          done;

  modport master (
    output ld, start, mode, amt, data_in,
    input  data_out, shift_out, busy, done
  );

  modport slave (
    input  ld, start, mode, amt, data_in,
    output data_out, shift_out, busy, done
  );
endinterface

// File: rtl/seq_shift_unit.sv
// ----------------------------------------------------------------------------
// seq_shift_unit
//   Multi-cycle shifter. It performs one single-bit step per clock for a
//   programmed number of steps. It supports logical and arithmetic right
//   shift, logical left shift, rotate right and rotate left. Modes 101-111
//   are reserved and hold the data.
//
//   Amounts of W or more are not clamped:
//     - logical shifts saturate to zero,
//     - arithmetic right saturates to copies of the sign bit,
//     - rotates wrap around.
//
//   Parameters
//     W        data width (W >= 2)
//     AW       shift-amount width; AW must be at least $clog2(W)+1
//     RST_VAL  reset value of data_out
//
//   Ports
//     clk  rising-edge clock
//     rst  synchronous, active-high reset; it overrides all other inputs
//     bus  seq_shift_unit_if.slave: ld/start/mode/amt/data_in in,
//          data_out/shift_out/busy/done out (all outputs registered)
// ----------------------------------------------------------------------------
module seq_shift_unit #(
  parameter int           W       = 8,
  parameter int           AW      = 4,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input logic            clk,
  input logic            rst,
  seq_shift_unit_if.slave bus
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  typedef enum logic [2:0] {
    MODE_LSR = 3'b000,
    MODE_ASR = 3'b001,
    MODE_LSL = 3'b010,
    MODE_ROR = 3'b011,
    MODE_ROL = 3'b100
  } mode_t;

  state_t        state;
  logic [AW-1:0] cnt;
  logic [2:0]    mode_q;
  logic [W-1:0]  data_q;
  logic          so_q;
  logic          busy_q;
  logic          done_q;

  // Result of one single-bit step applied to the current contents.
  logic [W-1:0]  step_d;
  logic          step_so;

  // NOTE: every output of a combinational block gets a default first, so a
  // path that does not assign it cannot infer a latch.
  always_comb begin
    step_d  = data_q;
    step_so = so_q;
    case (mode_q)
      MODE_LSR: begin
        step_d  = {1'b0, data_q[W-1:1]};
        step_so = data_q[0];
      end
      MODE_ASR: begin
        step_d  = {data_q[W-1], data_q[W-1:1]};
        step_so = data_q[0];
      end
      MODE_LSL: begin
        step_d  = {data_q[W-2:0], 1'b0};
        step_so = data_q[W-1];
      end
      MODE_ROR: begin
        step_d  = {data_q[0], data_q[W-1:1]};
        step_so = data_q[0];
      end
      MODE_ROL: begin
        step_d  = {data_q[W-2:0], data_q[W-1]};
        step_so = data_q[W-1];
      end
      default: ;  // reserved modes hold the data and shift_out
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values that were present before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      mode_q <= '0;
      data_q <= RST_VAL;
      so_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.ld) begin
            data_q <= bus.data_in;
          end
          if (bus.start) begin
            mode_q <= bus.mode;
            cnt    <= bus.amt;
            if (bus.amt == '0) begin
              // A zero amount completes at once without entering SHIFT.
              done_q <= 1'b1;
            end else begin
              state  <= SHIFT;
              busy_q <= 1'b1;
            end
          end
        end

        SHIFT: begin
          data_q <= step_d;
          so_q   <= step_so;
          cnt    <= cnt - AW'(1);
          if (cnt == AW'(1)) begin
            // Final step: leave SHIFT; busy and done swap on the same edge.
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.data_out  = data_q;
  assign bus.shift_out = so_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_seq_shift_unit.sv
// ----------------------------------------------------------------------------
// tb_seq_shift_unit
//   Self-checking bench for seq_shift_unit (W=8, AW=4, RST_VAL=0).
//   Operations come from a table of {inputs, expected result} records.
//   Expected results are queued when start is driven. A monitor pops and
//   compares them whenever the unit pulses done. Reset, back-to-back starts
//   and reset during an operation are exercised by hand-written sequences.
// ----------------------------------------------------------------------------
module tb_seq_shift_unit;

  localparam int           W       = 8;
  localparam int           AW      = 4;
  localparam logic [W-1:0] RST_VAL = '0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_shift_unit_if #(.W(W), .AW(AW)) bus ();

  seq_shift_unit #(.W(W), .AW(AW), .RST_VAL(RST_VAL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [W-1:0] data;
    logic         so;
  } exp_t;

  typedef struct {
    bit            sep_ld;  // load in its own cycle before start
    logic [W-1:0]  din;
    logic [2:0]    mode;
    logic [AW-1:0] amt;
    logic [W-1:0]  exp_d;
    logic          exp_so;
  } vec_t;

  exp_t expq[$];
  vec_t vecs[11];

  int   errors   = 0;
  int   checks   = 0;
  int   cyc      = 0;
  int   busy_cnt = 0;
  logic so_model = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: it samples on the falling edge, away from the
  // active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        check("done_busy_overlap", 32'(bus.busy), 32'd0);
        if (expq.size() == 0) begin
          check("unexpected_done", 32'(bus.done), 32'd0);
        end else begin
          exp_t e;
          e = expq.pop_front();
          check("result_data", 32'(bus.data_out), 32'(e.data));
          check("result_shift_out", 32'(bus.shift_out), 32'(e.so));
        end
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int   start_cyc;
    int   busy0;
    logic got_done;
    if (v.sep_ld) begin
      bus.ld      = 1'b1;
      bus.data_in = v.din;
      @(posedge clk); #1;
      bus.ld = 1'b0;
      @(negedge clk);
      check("load_data", 32'(bus.data_out), 32'(v.din));
      check("load_keeps_shift_out", 32'(bus.shift_out), 32'(so_model));
      @(posedge clk); #1;
    end
    bus.start   = 1'b1;
    bus.ld      = !v.sep_ld;
    bus.data_in = v.din;
    bus.mode    = v.mode;
    bus.amt     = v.amt;
    expq.push_back(exp_t'{v.exp_d, v.exp_so});
    @(posedge clk); #1;
    start_cyc = cyc;
    busy0     = busy_cnt;
    if (v.amt >= AW'(2)) begin
      // Commands presented while busy must be ignored.
      bus.start   = 1'b1;
      bus.ld      = 1'b1;
      bus.data_in = ~v.din;
      bus.mode    = v.mode ^ 3'b011;
      bus.amt     = AW'(1);
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    bus.ld    = 1'b0;
    got_done  = 1'b0;
    for (int i = 0; i < 100 && !got_done; i++) begin
      @(negedge clk);
      if (bus.done) got_done = 1'b1;
    end
    #1;
    check("done_seen", 32'(got_done), 32'd1);
    check("done_latency", 32'(cyc - start_cyc), 32'(v.amt));
    check("busy_cycles", 32'(busy_cnt - busy0), 32'(v.amt));
    @(negedge clk);
    check("done_one_cycle", 32'(bus.done), 32'd0);
    so_model = v.exp_so;
  endtask

  initial begin
    int d1;
    int d2;
    int ndone;

    //         sep  din    mode    amt    exp_d  exp_so
    vecs[0]  = '{1, 8'hA5, 3'b001, 4'd3,  8'hF4, 1'b1};  // arithmetic right
    vecs[1]  = '{0, 8'hA5, 3'b010, 4'd4,  8'h50, 1'b0};  // ld+start, left
    vecs[2]  = '{0, 8'h3C, 3'b011, 4'd8,  8'h3C, 1'b0};  // rotate full turn
    vecs[3]  = '{0, 8'hFF, 3'b000, 4'd9,  8'h00, 1'b0};  // logical saturate
    vecs[4]  = '{0, 8'h80, 3'b001, 4'd15, 8'hFF, 1'b1};  // sign saturate
    vecs[5]  = '{1, 8'h81, 3'b100, 4'd1,  8'h03, 1'b1};  // rotate left
    vecs[6]  = '{0, 8'h01, 3'b011, 4'd1,  8'h80, 1'b1};  // rotate right wrap
    vecs[7]  = '{1, 8'h5A, 3'b101, 4'd3,  8'h5A, 1'b1};  // reserved holds
    vecs[8]  = '{0, 8'h5A, 3'b000, 4'd0,  8'h5A, 1'b1};  // zero amount
    vecs[9]  = '{0, 8'h01, 3'b010, 4'd8,  8'h00, 1'b1};  // left saturate
    vecs[10] = '{1, 8'h02, 3'b000, 4'd2,  8'h00, 1'b1};  // logical right

    // Reset dominates start and ld.
    rst         = 1'b1;
    bus.start   = 1'b1;
    bus.ld      = 1'b1;
    bus.data_in = 8'hFF;
    bus.mode    = 3'b000;
    bus.amt     = 4'd3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_data_out", 32'(bus.data_out), 32'(RST_VAL));
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_shift_out", 32'(bus.shift_out), 32'd0);
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.ld    = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) run_vec(vecs[i]);

    // Start held high: back-to-back operations every amt+1 cycles.
    bus.ld      = 1'b1;
    bus.data_in = 8'hF0;
    @(posedge clk); #1;
    bus.ld    = 1'b0;
    bus.start = 1'b1;
    bus.mode  = 3'b000;
    bus.amt   = 4'd2;
    expq.push_back(exp_t'{8'h3C, 1'b0});
    expq.push_back(exp_t'{8'h0F, 1'b0});
    ndone = 0;
    d1    = 0;
    d2    = 0;
    for (int i = 0; i < 40 && ndone < 2; i++) begin
      @(negedge clk);
      if (bus.done) begin
        ndone++;
        if (ndone == 1) d1 = cyc; else d2 = cyc;
      end
    end
    bus.start = 1'b0;
    check("b2b_done_count", 32'(ndone), 32'd2);
    check("b2b_period", 32'(d2 - d1), 32'd3);
    repeat (2) @(posedge clk);
    #1;

    // Reset in the middle of a rotate-left by 6.
    bus.ld      = 1'b1;
    bus.start   = 1'b1;
    bus.data_in = 8'h81;
    bus.mode    = 3'b100;
    bus.amt     = 4'd6;
    @(posedge clk); #1;
    bus.ld    = 1'b0;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("abort_after_2_steps", 32'(bus.data_out), 32'h06);
    rst = 1'b1;
    @(negedge clk);
    check("abort_data_out", 32'(bus.data_out), 32'(RST_VAL));
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_shift_out", 32'(bus.shift_out), 32'd0);
    rst      = 1'b0;
    so_model = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_no_done", 32'(bus.done), 32'd0);
    end
    @(posedge clk); #1;
    run_vec('{0, 8'h81, 3'b100, 4'd6, 8'h60, 1'b0});

    check("scoreboard_drained", 32'(expq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
